// File: rtl/cv_bus_master.sv
// Z80-style bus-cycle initiator: turns single requests into T-state-accurate MREQ/IORQ/RD/WR strobes.
// Optional refresh T-states after mem reads when CV_BUS_RFSH_EN is defined.
module cv_bus_master #(
  parameter int IO_AUTO_WAIT = 1
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        clk_en_i,
  input  logic        req_i,
  input  logic [1:0]  req_type_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_data_i,
  output logic        req_ready_o,
  output logic        done_o,
  output logic [7:0]  rdata_o,
  output logic [15:0] a_o,
  output logic [7:0]  d_o,
  output logic        d_oe_o,
  input  logic [7:0]  d_i,
  input  logic        wait_n_i,
  output logic        mreq_n_o,
  output logic        iorq_n_o,
  output logic        rd_n_o,
  output logic        wr_n_o,
  output logic        rfsh_n_o
);

  localparam bit AUTO_WAIT = (IO_AUTO_WAIT != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_TW,
    S_T3
`ifdef CV_BUS_RFSH_EN
    ,
    S_R1,
    S_R2
`endif
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] typ_q, cur_type;
  logic       is_io, is_wr;
  logic       mreq_nxt, iorq_nxt, rd_nxt, wr_nxt, doe_nxt;
`ifdef CV_BUS_RFSH_EN
  logic       rfsh_nxt;
  logic [6:0] r_cnt;
`endif

  // In IDLE the strobes for T1 must be decoded from the incoming request, not the latched type.
  assign cur_type = (state == S_IDLE) ? req_type_i : typ_q;
  assign is_io    = cur_type[1];
  assign is_wr    = cur_type[0];

  always_comb begin
    state_nxt = state;
    if (clk_en_i) begin
      case (state)
        S_IDLE: if (req_i) state_nxt = S_T1;
        S_T1:   state_nxt = S_T2;
        S_T2:   state_nxt = ((is_io && AUTO_WAIT) || !wait_n_i) ? S_TW : S_T3;
        S_TW:   state_nxt = wait_n_i ? S_T3 : S_TW;
`ifdef CV_BUS_RFSH_EN
        S_T3:   state_nxt = (typ_q == 2'b00) ? S_R1 : S_IDLE;
        S_R1:   state_nxt = S_R2;
        S_R2:   state_nxt = S_IDLE;
`else
        S_T3:   state_nxt = S_IDLE;
`endif
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Strobe pattern for the state being entered; registered on the same tick.
  always_comb begin
    mreq_nxt = 1'b1;
    iorq_nxt = 1'b1;
    rd_nxt   = 1'b1;
    wr_nxt   = 1'b1;
    doe_nxt  = 1'b0;
`ifdef CV_BUS_RFSH_EN
    rfsh_nxt = 1'b1;
`endif
    case (state_nxt)
      S_T1: begin
        mreq_nxt = is_io;
        rd_nxt   = is_io | is_wr;
        doe_nxt  = is_wr;
      end
      S_T2, S_TW: begin
        mreq_nxt = is_io;
        iorq_nxt = !is_io;
        rd_nxt   = is_wr;
        wr_nxt   = !is_wr;
        doe_nxt  = is_wr;
      end
      S_T3: doe_nxt = is_wr;
`ifdef CV_BUS_RFSH_EN
      S_R1: rfsh_nxt = 1'b0;
      S_R2: begin
        rfsh_nxt = 1'b0;
        mreq_nxt = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= S_IDLE;
      typ_q       <= 2'b00;
      req_ready_o <= 1'b1;
      done_o      <= 1'b0;
      rdata_o     <= 8'h00;
      a_o         <= 16'h0000;
      d_o         <= 8'h00;
      d_oe_o      <= 1'b0;
      mreq_n_o    <= 1'b1;
      iorq_n_o    <= 1'b1;
      rd_n_o      <= 1'b1;
      wr_n_o      <= 1'b1;
`ifdef CV_BUS_RFSH_EN
      rfsh_n_o    <= 1'b1;
      r_cnt       <= 7'd0;
`endif
    end else begin
      done_o <= 1'b0;
      if (clk_en_i) begin
        state       <= state_nxt;
        req_ready_o <= (state_nxt == S_IDLE);
        mreq_n_o    <= mreq_nxt;
        iorq_n_o    <= iorq_nxt;
        rd_n_o      <= rd_nxt;
        wr_n_o      <= wr_nxt;
        d_oe_o      <= doe_nxt;
        if (state == S_IDLE && req_i) begin
          typ_q <= req_type_i;
          a_o   <= req_addr_i;
          d_o   <= req_data_i;
        end
        // Capture on the edge leaving the strobed phase, while RD is still low.
        if ((state == S_T2 || state == S_TW) && state_nxt == S_T3 && !typ_q[0])
          rdata_o <= d_i;
        if (state != S_IDLE && state_nxt == S_IDLE)
          done_o <= 1'b1;
`ifdef CV_BUS_RFSH_EN
        rfsh_n_o <= rfsh_nxt;
        if (state_nxt == S_R1)
          a_o <= {9'b0, r_cnt};
        if (state == S_R2)
          r_cnt <= r_cnt + 7'd1;
`endif
      end
    end
  end

`ifndef CV_BUS_RFSH_EN
  assign rfsh_n_o = 1'b1;
`endif

endmodule

// File: tb/tb_cv_bus_master.sv
// Directed bench for cv_bus_master: per-transaction expectations queued at issue, compared at done_o.
module tb_cv_bus_master;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        clk_en_i = 1'b0;
  logic        req_i = 1'b0;
  logic [1:0]  req_type_i = 2'b00;
  logic [15:0] req_addr_i = 16'h0000;
  logic [7:0]  req_data_i = 8'h00;
  logic        req_ready_o, done_o, d_oe_o;
  logic [7:0]  rdata_o, d_o;
  logic [15:0] a_o;
  logic [7:0]  d_i = 8'h00;
  logic        wait_n_i = 1'b1;
  logic        mreq_n_o, iorq_n_o, rd_n_o, wr_n_o, rfsh_n_o;

  cv_bus_master #(.IO_AUTO_WAIT(1)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .clk_en_i(clk_en_i),
    .req_i(req_i), .req_type_i(req_type_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .done_o(done_o), .rdata_o(rdata_o),
    .a_o(a_o), .d_o(d_o), .d_oe_o(d_oe_o), .d_i(d_i), .wait_n_i(wait_n_i),
    .mreq_n_o(mreq_n_o), .iorq_n_o(iorq_n_o), .rd_n_o(rd_n_o), .wr_n_o(wr_n_o),
    .rfsh_n_o(rfsh_n_o)
  );

  always #5 clk_i = ~clk_i;

  // One T-state every two clk_i cycles, so a stretched done_o would be visible.
  initial forever begin
    @(posedge clk_i);
    #1 clk_en_i = ~clk_en_i;
  end

  typedef struct {
    logic [1:0]  typ;
    logic [15:0] addr;
    logic [7:0]  data;
    int          ts, mreq, iorq, rd, wr, doe, rfsh;
    logic [7:0]  rdata;
    logic [15:0] raddr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          waits_left = 0;
  logic [6:0]  rcnt_model = 7'd0;
  logic [7:0]  rdata_model = 8'h00;

  int          m_idx, m_ts, m_mreq, m_iorq, m_rd, m_wr, m_doe, m_rfsh;
  logic [15:0] m_raddr;
  logic        tick_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    m_idx = 0; m_ts = 0; m_mreq = 0; m_iorq = 0; m_rd = 0; m_wr = 0; m_doe = 0; m_rfsh = 0;
    m_raddr = 16'h0000;
  endtask

  // Monitor: one sample per T-state (negedge after a tick edge); also drives WAIT.
  initial begin
    exp_t e;
    clear_mon();
    forever begin
      @(posedge clk_i);
      tick_q = clk_en_i;
      @(negedge clk_i);
      if (!reset_n_i) begin
        clear_mon();
        wait_n_i = 1'b1;
        continue;
      end
      if (done_o) begin
        if (!tick_q) check("done_width", done_o, 1'b0);
        else if (sb.size() == 0) check("done_unexpected", done_o, 1'b0);
        else begin
          e = sb.pop_front();
          check("tstates", m_ts, e.ts);
          check("mreq_low", m_mreq, e.mreq);
          check("iorq_low", m_iorq, e.iorq);
          check("rd_low", m_rd, e.rd);
          check("wr_low", m_wr, e.wr);
          check("doe_high", m_doe, e.doe);
          check("rfsh_low", m_rfsh, e.rfsh);
          check("rdata", rdata_o, e.rdata);
          if (e.rfsh > 0) check("rfsh_addr", m_raddr, e.raddr);
        end
      end
      if (tick_q) begin
        if (req_ready_o) clear_mon();
        else begin
          m_idx++;
          m_ts++;
          if (!mreq_n_o) m_mreq++;
          if (!iorq_n_o) m_iorq++;
          if (!rd_n_o) m_rd++;
          if (!wr_n_o) m_wr++;
          if (d_oe_o) m_doe++;
          if (!rfsh_n_o) begin
            m_rfsh++;
            if (m_rfsh == 1) m_raddr = a_o;
          end
          if (m_idx == 1 && sb.size() > 0) begin
            check("t1_addr", a_o, sb[0].addr);
            if (sb[0].typ[0]) check("t1_wdata", d_o, sb[0].data);
          end
        end
        if (!req_ready_o && m_idx >= 2 && waits_left > 0) begin
          wait_n_i = 1'b0;
          waits_left--;
        end else wait_n_i = 1'b1;
      end
    end
  end

  task automatic drive_req(input logic [1:0] typ, input logic [15:0] addr, input logic [7:0] data);
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!(clk_en_i && req_ready_o) && n < 200);
    check("accept_ready", req_ready_o, 1'b1);
    req_type_i = typ; req_addr_i = addr; req_data_i = data; req_i = 1'b1;
    @(posedge clk_i);
    #1 req_i = 1'b0;
  endtask

  // mem waits only; IO cycles use the automatic wait state.
  task automatic issue(input logic [1:0] typ, input logic [15:0] addr, input logic [7:0] data,
                       input logic [7:0] din, input int waits);
    exp_t e;
    int   n;
    bit   io, wr;
    io = typ[1]; wr = typ[0];
    e.typ = typ; e.addr = addr; e.data = data; e.raddr = 16'h0000; e.rfsh = 0;
    if (!io) begin
      e.ts = 3 + waits; e.mreq = 2 + waits; e.iorq = 0;
      e.rd = wr ? 0 : 2 + waits; e.wr = wr ? 1 + waits : 0; e.doe = wr ? 3 + waits : 0;
    end else begin
      e.ts = 4; e.mreq = 0; e.iorq = 2;
      e.rd = wr ? 0 : 2; e.wr = wr ? 2 : 0; e.doe = wr ? 4 : 0;
    end
`ifdef CV_BUS_RFSH_EN
    if (typ == 2'b00) begin
      e.ts += 2; e.mreq += 1; e.rfsh = 2;
      e.raddr = {9'b0, rcnt_model};
      rcnt_model = rcnt_model + 7'd1;
    end
`endif
    if (!wr) rdata_model = din;
    e.rdata = rdata_model;
    sb.push_back(e);
    d_i = din;
    waits_left = waits;
    drive_req(typ, addr, data);
    n = 0;
    while (sb.size() > 0 && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    check("complete", sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_i);
    check("rst_mreq", mreq_n_o, 1'b1);
    check("rst_iorq", iorq_n_o, 1'b1);
    check("rst_rd", rd_n_o, 1'b1);
    check("rst_wr", wr_n_o, 1'b1);
    check("rst_rfsh", rfsh_n_o, 1'b1);
    check("rst_doe", d_oe_o, 1'b0);
    check("rst_a", a_o, 16'h0000);
    check("rst_d", d_o, 8'h00);
    check("rst_rdata", rdata_o, 8'h00);
    check("rst_done", done_o, 1'b0);
    check("rst_ready", req_ready_o, 1'b1);
    reset_n_i = 1'b1;

    issue(2'b00, 16'h1234, 8'h00, 8'hA5, 0);
    issue(2'b00, 16'h4321, 8'h00, 8'h5A, 1);
    issue(2'b01, 16'h7000, 8'h3C, 8'h00, 2);
    issue(2'b11, 16'h00BE, 8'h81, 8'h00, 0);
    issue(2'b10, 16'h00FC, 8'h00, 8'h7F, 0);
    check("a_hold_idle", a_o,
`ifdef CV_BUS_RFSH_EN
          16'h00FC
`else
          16'h00FC
`endif
    );

    // Reset in the middle of a long wait: no done, strobes released at once.
    d_i = 8'h11;
    waits_left = 20;
    drive_req(2'b00, 16'h2000, 8'h00);
    repeat (10) @(negedge clk_i);
    check("pre_rst_mreq", mreq_n_o, 1'b0);
    check("pre_rst_rd", rd_n_o, 1'b0);
    #2 reset_n_i = 1'b0;
    #1;
    check("arst_mreq", mreq_n_o, 1'b1);
    check("arst_rd", rd_n_o, 1'b1);
    check("arst_ready", req_ready_o, 1'b1);
    check("arst_done", done_o, 1'b0);
    check("arst_rdata", rdata_o, 8'h00);
    waits_left = 0;
    rcnt_model = 7'd0;
    rdata_model = 8'h00;
    repeat (3) @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (10) @(negedge clk_i);
    check("post_rst_done", done_o, 1'b0);

    issue(2'b00, 16'h0100, 8'h00, 8'hC3, 0);
    for (int i = 0; i < 130; i++)
      issue(2'b00, 16'(16'h8000 + i), 8'h00, 8'(i * 7 + 1), 0);
    issue(2'b01, 16'h9000, 8'hE7, 8'h00, 0);
    issue(2'b00, 16'h9001, 8'h00, 8'h42, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
